nf_tpu_ins_issuer: RTL and testbench

//   Head-of-chain instruction source for the TPU instruction bus. Buffers 64-bit

---
 rtl/nf_tpu_ins_issuer_if.sv | 24 ++
 rtl/nf_tpu_ins_issuer.sv | 92 +++++++++
 tb/tb_nf_tpu_ins_issuer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nf_tpu_ins_issuer_if.sv
// nf_tpu_ins_issuer_if: host push port and instruction-chain outputs of the issuer
interface nf_tpu_ins_issuer_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic [63:0]   host_ins;
    logic          host_ins_valid;
    logic          host_ins_ready;
    logic          start;
    logic [63:0]   out_ins;
    logic          out_ins_valid;
    logic          busy;
    logic          halted;
    logic [31:0]   issued_count;
    logic [LW-1:0] fifo_level;
    modport master (
        output host_ins, host_ins_valid, start,
        input  host_ins_ready, out_ins, out_ins_valid, busy, halted, issued_count, fifo_level
    );
    modport slave (
        input  host_ins, host_ins_valid, start,
        output host_ins_ready, out_ins, out_ins_valid, busy, halted, issued_count, fifo_level
    );
endinterface

// File: rtl/nf_tpu_ins_issuer.sv
// nf_tpu_ins_issuer: host-fed instruction FIFO issuing onto the TPU chain, executing WAIT/HALT locally
module nf_tpu_ins_issuer #(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] WAIT_OP = 8'hF0,
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input logic                sys_clk,
    input logic                sys_rst_n,
    nf_tpu_ins_issuer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   issued_count_q, issued_count_d;
    logic [63:0]   out_ins_q, out_ins_d;
    logic          out_valid_q, out_valid_d;
    logic [63:0]   head;
    logic          push, pop, is_wait, is_halt, emit;

    assign head    = mem_q[rd_ptr_q];
    assign push    = bus.host_ins_valid && bus.host_ins_ready;
    assign pop     = (state_q == S_RUN) && (level_q != '0);
    assign is_wait = head[7:0] == WAIT_OP;
    assign is_halt = head[7:0] == HALT_OP;
    assign emit    = pop && !is_wait && !is_halt;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        level_d        = level_q + LW'(push) - LW'(pop);
        out_valid_d    = emit;
        out_ins_d      = emit ? head : '0;
        issued_count_d = issued_count_q + 32'(emit);
        case (state_q)
            S_IDLE, S_HALT: state_d = bus.start ? S_RUN : state_q;
            S_RUN: begin
                if (pop && is_halt) state_d = S_HALT;
                // a zero-length WAIT is consumed without leaving RUN
                else if (pop && is_wait && head[39:8] != '0) begin
                    state_d = S_WAIT;
                    cnt_d   = head[39:8];
                end
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 32'd1;
                state_d = (cnt_q == 32'd1) ? S_RUN : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            issued_count_q <= '0;
            out_ins_q      <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_ptr_q       <= wr_ptr_q + AW'(push);
            rd_ptr_q       <= rd_ptr_q + AW'(pop);
            level_q        <= level_d;
            issued_count_q <= issued_count_d;
            out_ins_q      <= out_ins_d;
            out_valid_q    <= out_valid_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.host_ins;
    end

    assign bus.host_ins_ready = level_q != LW'(DEPTH);
    assign bus.out_ins        = out_ins_q;
    assign bus.out_ins_valid  = out_valid_q;
    assign bus.busy           = (state_q == S_RUN) || (state_q == S_WAIT);
    assign bus.halted         = state_q == S_HALT;
    assign bus.issued_count   = issued_count_q;
    assign bus.fifo_level     = level_q;
endmodule

// File: tb/tb_nf_tpu_ins_issuer.sv
// tb_nf_tpu_ins_issuer: directed vector table plus hand-written sequences for the issuer
module tb_nf_tpu_ins_issuer;
    localparam int DEPTH = 16;

    typedef struct {
        logic [63:0] ins;
        logic        vld;
        logic        start;
        logic        exp_vld;
        logic [63:0] exp_ins;
        logic [31:0] exp_cnt;
        logic [4:0]  exp_lvl;
        logic        exp_busy;
    } vec_t;

    localparam logic [63:0] I0 = 64'h1111_2222_3333_4405;
    localparam logic [63:0] I1 = 64'hAAAA_BBBB_CCCC_DD01;
    localparam logic [63:0] I2 = 64'h0123_4567_89AB_CD05;
    localparam logic [63:0] A  = 64'h0000_00A0_0000_0011;
    localparam logic [63:0] W3 = 64'h0000_0000_0000_03F0;
    localparam logic [63:0] B  = 64'hBBBB_0000_0000_0022;
    localparam logic [63:0] C  = 64'hCCCC_0000_0000_0033;
    localparam logic [63:0] W0 = 64'hDEAD_0000_0000_00F0;
    localparam logic [63:0] D  = 64'hDDDD_0000_0000_0044;
    localparam logic [63:0] HL = 64'h0000_0000_0000_12FF;
    localparam logic [63:0] X  = 64'h7777_0000_0000_0055;
    localparam logic [63:0] E  = 64'hEEEE_0000_0000_0066;
    localparam logic [63:0] W5 = 64'h0000_0000_0000_05F0;
    localparam logic [63:0] Y  = 64'h9999_0000_0000_0077;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails = 0;
    vec_t vt [20];

    nf_tpu_ins_issuer_if #(.DEPTH(DEPTH)) bus ();
    nf_tpu_ins_issuer #(.DEPTH(DEPTH)) dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [63:0] ins, input logic vld, input logic st);
        bus.host_ins = ins;
        bus.host_ins_valid = vld;
        bus.start = st;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(64'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(logic [63:0] ins, logic vld, logic st, logic ev,
                                logic [63:0] ei, logic [31:0] ec, logic [4:0] el, logic eb);
        vec_t v;
        v.ins = ins; v.vld = vld; v.start = st; v.exp_vld = ev;
        v.exp_ins = ei; v.exp_cnt = ec; v.exp_lvl = el; v.exp_busy = eb;
        return v;
    endfunction

    function automatic logic [63:0] fill_ins(int i);
        return 64'hC0DE_0000_0000_0020 | (64'(i) << 16);
    endfunction

    function automatic logic [63:0] p_ins(int i);
        return 64'h5000_0000_0000_0042 | (64'(i) << 8);
    endfunction

    initial begin
        int k;
        // reset held with pushes and start active
        rst_n = 1'b0;
        drive(64'hFFFF_FFFF_FFFF_FF05, 1'b1, 1'b1);
        repeat (2) tick();
        check("rst valid", bus.out_ins_valid, 0);
        check("rst ins", bus.out_ins, 0);
        check("rst count", bus.issued_count, 0);
        check("rst level", bus.fifo_level, 0);
        check("rst ready", bus.host_ins_ready, 1);
        check("rst busy", bus.busy, 0);
        check("rst halted", bus.halted, 0);
        rst_n = 1'b1;
        drive(64'h0, 1'b0, 1'b0);

        // ins, vld, start | valid, ins, count, level, busy
        vt[0]  = mk(I0, 1, 0, 0, 0,  0, 1, 0);
        vt[1]  = mk(I1, 1, 0, 0, 0,  0, 2, 0);
        vt[2]  = mk(I2, 1, 0, 0, 0,  0, 3, 0);
        vt[3]  = mk(0,  0, 1, 0, 0,  0, 3, 1);
        vt[4]  = mk(0,  0, 0, 1, I0, 1, 2, 1);
        vt[5]  = mk(0,  0, 0, 1, I1, 2, 1, 1);
        vt[6]  = mk(0,  0, 0, 1, I2, 3, 0, 1);
        vt[7]  = mk(0,  0, 0, 0, 0,  3, 0, 1);
        vt[8]  = mk(A,  1, 0, 0, 0,  3, 1, 1);
        vt[9]  = mk(W3, 1, 0, 1, A,  4, 1, 1);
        vt[10] = mk(B,  1, 0, 0, 0,  4, 1, 1);
        vt[11] = mk(0,  0, 1, 0, 0,  4, 1, 1);
        vt[12] = mk(0,  0, 0, 0, 0,  4, 1, 1);
        vt[13] = mk(0,  0, 0, 0, 0,  4, 1, 1);
        vt[14] = mk(0,  0, 0, 1, B,  5, 0, 1);
        vt[15] = mk(C,  1, 0, 0, 0,  5, 1, 1);
        vt[16] = mk(W0, 1, 0, 1, C,  6, 1, 1);
        vt[17] = mk(D,  1, 0, 0, 0,  6, 1, 1);
        vt[18] = mk(0,  0, 0, 1, D,  7, 0, 1);
        vt[19] = mk(0,  0, 0, 0, 0,  7, 0, 1);
        foreach (vt[i]) begin
            drive(vt[i].ins, vt[i].vld, vt[i].start);
            tick();
            check($sformatf("vec%0d valid", i), bus.out_ins_valid, vt[i].exp_vld);
            check($sformatf("vec%0d ins", i), bus.out_ins, vt[i].exp_ins);
            check($sformatf("vec%0d count", i), bus.issued_count, vt[i].exp_cnt);
            check($sformatf("vec%0d level", i), bus.fifo_level, vt[i].exp_lvl);
            check($sformatf("vec%0d busy", i), bus.busy, vt[i].exp_busy);
        end
        drive(64'h0, 1'b0, 1'b0);

        // fill past capacity in IDLE
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(fill_ins(i), 1'b1, 1'b0);
            tick();
            if (i == DEPTH - 2) check("fill ready pre-full", bus.host_ins_ready, 1);
            if (i == DEPTH - 1) begin
                check("fill ready full", bus.host_ins_ready, 0);
                check("fill level full", bus.fifo_level, DEPTH);
            end
        end
        check("fill level after drops", bus.fifo_level, DEPTH);
        drive(64'h0, 1'b0, 1'b1);
        tick();
        drive(64'h0, 1'b0, 1'b0);
        k = 0;
        for (int c = 0; c < DEPTH + 4; c++) begin
            tick();
            if (bus.out_ins_valid) begin
                check($sformatf("fill data%0d", k), bus.out_ins, fill_ins(k));
                k++;
            end
        end
        check("fill emitted", k, DEPTH);
        check("fill count", bus.issued_count, DEPTH);
        check("fill end valid", bus.out_ins_valid, 0);
        check("fill end ins", bus.out_ins, 0);
        check("fill end ready", bus.host_ins_ready, 1);

        // HALT holds later entries until the next start
        do_reset();
        drive(A, 1'b1, 1'b0); tick();
        drive(HL, 1'b1, 1'b0); tick();
        drive(B, 1'b1, 1'b0); tick();
        drive(64'h0, 1'b0, 1'b1); tick();
        drive(64'h0, 1'b0, 1'b0);
        check("halt run busy", bus.busy, 1);
        check("halt run valid", bus.out_ins_valid, 0);
        tick();
        check("halt A valid", bus.out_ins_valid, 1);
        check("halt A ins", bus.out_ins, A);
        tick();
        check("halt halted", bus.halted, 1);
        check("halt busy", bus.busy, 0);
        check("halt no emit", bus.out_ins_valid, 0);
        check("halt level", bus.fifo_level, 1);
        drive(X, 1'b1, 1'b0); tick();
        drive(64'h0, 1'b0, 1'b0);
        check("halt push level", bus.fifo_level, 2);
        check("halt still halted", bus.halted, 1);
        check("halt push no emit", bus.out_ins_valid, 0);
        drive(64'h0, 1'b0, 1'b1); tick();
        check("halt restart busy", bus.busy, 1);
        check("halt restart halted", bus.halted, 0);
        drive(64'h0, 1'b0, 1'b1); tick();
        drive(64'h0, 1'b0, 1'b0);
        check("halt B ins", bus.out_ins, B);
        tick();
        check("halt X ins", bus.out_ins, X);
        check("halt count", bus.issued_count, 3);
        tick();
        check("halt drain valid", bus.out_ins_valid, 0);
        check("halt drain busy", bus.busy, 1);
        check("halt drain level", bus.fifo_level, 0);

        // steady push/pop at level 1
        do_reset();
        drive(64'h0, 1'b0, 1'b1); tick();
        drive(p_ins(0), 1'b1, 1'b0); tick();
        check("pp level init", bus.fifo_level, 1);
        for (int i = 1; i <= 10; i++) begin
            drive(p_ins(i), 1'b1, 1'b0);
            tick();
            check($sformatf("pp level%0d", i), bus.fifo_level, 1);
            check($sformatf("pp ins%0d", i), bus.out_ins, p_ins(i - 1));
        end
        drive(64'h0, 1'b0, 1'b0); tick();
        check("pp last ins", bus.out_ins, p_ins(10));
        check("pp level end", bus.fifo_level, 0);
        check("pp count", bus.issued_count, 11);

        // issued_count wrap
        force dut.issued_count_d = 32'hFFFF_FFFF;
        tick();
        release dut.issued_count_d;
        check("wrap preload", bus.issued_count, 32'hFFFF_FFFF);
        drive(E, 1'b1, 1'b0); tick();
        drive(64'h0, 1'b0, 1'b0); tick();
        check("wrap valid", bus.out_ins_valid, 1);
        check("wrap ins", bus.out_ins, E);
        check("wrap count", bus.issued_count, 0);

        // reset during WAIT
        drive(W5, 1'b1, 1'b0); tick();
        drive(Y, 1'b1, 1'b0); tick();
        drive(64'h0, 1'b0, 1'b0); tick();
        check("wait busy", bus.busy, 1);
        check("wait level", bus.fifo_level, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("wrst busy", bus.busy, 0);
        check("wrst halted", bus.halted, 0);
        check("wrst level", bus.fifo_level, 0);
        check("wrst valid", bus.out_ins_valid, 0);
        check("wrst count", bus.issued_count, 0);
        check("wrst ready", bus.host_ins_ready, 1);
        repeat (8) tick();
        check("wrst idle valid", bus.out_ins_valid, 0);
        check("wrst idle busy", bus.busy, 0);
        check("wrst idle level", bus.fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
